// File: rtl/dtcm_sram_ctrl.sv
// Data-side ICB responder for a single-port on-chip data SRAM.
// One command per cycle, byte-masked stores, in-order responses behind a 2-deep buffer.
module dtcm_sram_ctrl #(
    parameter int unsigned   DW        = 32,
    parameter int unsigned   RAM_DEPTH = 14,
    parameter int unsigned   AW        = 32,
    parameter logic [AW-1:0] BASE_ADDR = 32'h8000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            dcache_icb_cmd_valid,
    output logic            dcache_icb_cmd_ready,
    input  logic            dcache_icb_cmd_read,
    input  logic [AW-1:0]   dcache_icb_cmd_addr,
    input  logic [DW-1:0]   dcache_icb_cmd_wdata,
    input  logic [DW/8-1:0] dcache_icb_cmd_wmask,
    output logic            dcache_icb_rsp_valid,
    input  logic            dcache_icb_rsp_ready,
    output logic [DW-1:0]   dcache_icb_rsp_rdata,
    output logic            dcache_icb_rsp_err,
    input  logic            flush
);

    localparam int unsigned MW    = DW / 8;
    localparam int unsigned WORDS = 1 << RAM_DEPTH;

    logic                 acc;
    logic                 pop;
    logic                 fifo_pop;
    logic                 s1_push;
    logic                 in_range;
    logic                 ram_en;
    logic                 ram_we;
    logic [RAM_DEPTH-1:0] widx;
    logic [2:0]           occ;
    logic [DW-1:0]        ram_rdata;
    logic [DW-1:0]        s1_rdata;
    logic [DW-1:0]        head_rdata;
    logic                 head_err;
    logic                 unused_addr_lsb;

    logic                 s1_v_q, s1_v_d;
    logic                 s1_ld_q, s1_ld_d;
    logic                 s1_err_q, s1_err_d;
    logic [1:0]           fifo_cnt_q, fifo_cnt_d;
    logic [1:0]           cnt_after;
    logic [DW-1:0]        fifo_data_q [2];
    logic [DW-1:0]        fifo_data_d [2];
    logic [1:0]           fifo_err_q, fifo_err_d;

    assign unused_addr_lsb = ^dcache_icb_cmd_addr[1:0];

    assign widx     = dcache_icb_cmd_addr[RAM_DEPTH+1:2];
    assign in_range = (dcache_icb_cmd_addr[AW-1:RAM_DEPTH+2] == BASE_ADDR[AW-1:RAM_DEPTH+2]);
    assign ram_en   = acc & in_range;
    assign ram_we   = ram_en & ~dcache_icb_cmd_read;

    // One narrow memory per byte lane keeps the byte-enable write a plain per-lane write.
    for (genvar b = 0; b < MW; b++) begin : g_lane
        logic [7:0] lane_mem [WORDS];
        logic [7:0] lane_rdata_q;

        always_ff @(posedge clk) begin
            if (ram_we && dcache_icb_cmd_wmask[b]) begin
                lane_mem[widx] <= dcache_icb_cmd_wdata[8*b +: 8];
            end
            if (ram_en && dcache_icb_cmd_read) begin
                lane_rdata_q <= lane_mem[widx];
            end
        end

        assign ram_rdata[8*b +: 8] = lane_rdata_q;
    end

    // S1 lives for exactly one cycle, so the lane read registers are its data stage.
    assign s1_rdata   = s1_ld_q ? ram_rdata : '0;
    assign head_rdata = (fifo_cnt_q != 2'd0) ? fifo_data_q[0] : s1_rdata;
    assign head_err   = (fifo_cnt_q != 2'd0) ? fifo_err_q[0]  : s1_err_q;

    assign dcache_icb_rsp_valid = (fifo_cnt_q != 2'd0) | s1_v_q;
    assign dcache_icb_rsp_rdata = dcache_icb_rsp_valid ? head_rdata : '0;
    assign dcache_icb_rsp_err   = dcache_icb_rsp_valid & head_err;

    assign pop      = dcache_icb_rsp_valid & dcache_icb_rsp_ready;
    assign fifo_pop = pop & (fifo_cnt_q != 2'd0);
    assign s1_push  = s1_v_q & ~(pop & (fifo_cnt_q == 2'd0));
    assign occ      = {1'b0, fifo_cnt_q} + {2'b00, s1_v_q};

    assign dcache_icb_cmd_ready = ~rst & ~flush & ((occ - {2'b00, pop}) < 3'd2);
    assign acc                  = dcache_icb_cmd_valid & dcache_icb_cmd_ready;

    always_comb begin
        s1_v_d   = acc;
        s1_ld_d  = acc & dcache_icb_cmd_read & in_range;
        s1_err_d = acc & ~in_range;

        fifo_data_d = fifo_data_q;
        fifo_err_d  = fifo_err_q;
        cnt_after   = fifo_cnt_q - {1'b0, fifo_pop};
        if (fifo_pop) begin
            fifo_data_d[0] = fifo_data_q[1];
            fifo_err_d[0]  = fifo_err_q[1];
        end
        // Occupancy gating guarantees cnt_after <= 1 whenever S1 is pushed.
        if (s1_push) begin
            fifo_data_d[cnt_after[0]] = s1_rdata;
            fifo_err_d[cnt_after[0]]  = s1_err_q;
        end
        fifo_cnt_d = cnt_after + {1'b0, s1_push};

        if (flush) begin
            s1_v_d     = 1'b0;
            fifo_cnt_d = 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q     <= 1'b0;
            s1_ld_q    <= 1'b0;
            s1_err_q   <= 1'b0;
            fifo_cnt_q <= 2'd0;
        end else begin
            s1_v_q     <= s1_v_d;
            s1_ld_q    <= s1_ld_d;
            s1_err_q   <= s1_err_d;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        fifo_data_q <= fifo_data_d;
        fifo_err_q  <= fifo_err_d;
    end

endmodule

// File: doc/dtcm_sram_ctrl.md
# dtcm_sram_ctrl

Data-side ICB responder that serves load/store commands from the AGU/LSU path into a single-port on-chip data SRAM. It accepts one command per cycle and performs writes with byte masks. Responses are returned strictly in order with one-cycle minimum latency, buffered up to two deep against `rsp_ready` back-pressure. Pipeline `flush` discards undelivered responses.

## Interface
Parameters:
- `DW`, 32, data width in bits; the byte-mask width is `DW/8`.
- `RAM_DEPTH`, 14, log2 of the number of `DW`-bit words (default 16K words = 64 KiB).
- `BASE_ADDR`, 32'h8000_0000, region base; only bits above `RAM_DEPTH+2` are compared.

Ports:
- `clk`  in  1  clock; everything is sampled on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `dcache_icb_cmd_valid`  in  1  command valid.
- `dcache_icb_cmd_ready`  out  1  command accepted when high together with valid.
- `dcache_icb_cmd_read`  in  1  1 = load, 0 = store.
- `dcache_icb_cmd_addr`  in  `HiCore_ADDR_SIZE`  byte address; bits [1:0] are ignored.
- `dcache_icb_cmd_wdata`  in  `DW`  store data.
- `dcache_icb_cmd_wmask`  in  `DW/8`  byte enables for stores.
- `dcache_icb_rsp_valid`  out  1  response valid.
- `dcache_icb_rsp_ready`  in  1  response consumed when high together with valid.
- `dcache_icb_rsp_rdata`  out  `DW`  load data; 0 for stores and for errors.
- `dcache_icb_rsp_err`  out  1  address outside the region.
- `flush`  in  1  discard all undelivered responses.

## Operation
- Accept condition: `cmd_valid & cmd_ready` (the "acc" event).
- Word index is `addr[RAM_DEPTH+1:2]`. A command is in range iff `addr[HiCore_ADDR_SIZE-1:RAM_DEPTH+2] == BASE_ADDR[HiCore_ADDR_SIZE-1:RAM_DEPTH+2]`.
- Store, in range:
  - SRAM is written in the acc cycle; only bytes with `wmask` bit = 1 change.
  - Response is `rdata=0`, `err=0`.
  - A `wmask` of all zeros is legal: no bytes change and a response is still produced.
- Load, in range: SRAM is read in the acc cycle and the data is registered into stage S1.
- Any out-of-range command: no SRAM access; response is `rdata=0`, `err=1`.
- Response buffering:
  - S1 holds the command issued last cycle.
  - A 2-entry FIFO holds completed responses.
  - The output is the FIFO head when the FIFO is non-empty, otherwise S1 (bypass).
  - S1 moves into the FIFO when it is not the entry being delivered.
- Occupancy: `occ = fifo_cnt + s1_v`. `cmd_ready = !rst & !flush & (occ - pop) < 2`, where `pop = rsp_valid & rsp_ready`. Occupancy never exceeds 2.
- Ordering: strictly in order. Read-after-write to the same word, issued back-to-back, returns the newly written bytes.
- Flush:
  - In the flush cycle, `s1_v` and `fifo_cnt` are cleared and `cmd_ready=0`.
  - A response handshaking in the flush cycle still counts as delivered.
  - Stores accepted before the flush remain written.

## Timing
- Reset values: `cmd_ready=0` while `rst=1`, then 1 in the first cycle after. `rsp_valid=0`, `rsp_rdata=0`, `rsp_err=0`, `s1_v=0`, `fifo_cnt=0`. SRAM contents are not reset.
- Latency: acc in cycle N gives `rsp_valid=1` in cycle N+1 when no older response is pending.
- Throughput: 1 command/cycle sustained while `rsp_ready=1`.
- Back-pressure with `rsp_ready=0`: at most 2 commands are accepted, after which `cmd_ready=0`. `cmd_ready` returns combinationally in the cycle a pop occurs.
- While `rsp_valid=1 & rsp_ready=0`, `rsp_rdata` and `rsp_err` hold stable.
- Simultaneous push and pop with FIFO full-minus-one: the FIFO count is unchanged and no entry is lost.
- Reset asserted mid-transfer: all pending responses are dropped the next edge, identical to flush. SRAM is unaffected.
- Flush and acc never coincide, because `cmd_ready` is forced low during flush.

## Test plan
- Store `addr=0x8000_0010`, `wdata=0xDEADBEEF`, `wmask=4'hF`, then a load from the same address in the next cycle → store response `rdata=0`, `err=0` at N+1; load response `0xDEADBEEF` at N+2.
- Byte-mask merge: store `0x11223344` with mask `F`, then store `0xAABBCCDD` with mask `4'b0101`, then load → `0x11BB33DD`.
- Back-pressure: `rsp_ready=0` while 4 loads are offered → exactly 2 accepted and `cmd_ready=0`. Raising `rsp_ready` delivers both in order with stable data, and the remaining loads then flow at 1/cycle.
- Out of range: load `0x9000_0000` → `err=1`, `rdata=0`. Store to `0x0000_0004` → `err=1`, and a following in-range load shows the SRAM unchanged.
- Flush with 2 responses pending and `rsp_ready=0` → `rsp_valid=0` the next cycle and `cmd_ready=0` during the flush cycle. A store accepted before the flush is visible to a later load.
- Reset mid-stream with 2 pending responses → all outputs at reset values after one edge, `cmd_ready=1` the cycle after reset is released, and no stale response appears.
